// File: rtl/aes_request_guard_pkg.sv
// Shared types and constants for the AES request guard.
package aes_guard_pkg;
  localparam int AES_BLOCK_W = 128;

  localparam int DEF_MAX_RETRY      = 2;
  localparam int DEF_FAULT_LIMIT    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_CNT_W          = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    LOCK  = 3'd4
  } state_e;
endpackage

// File: rtl/aes_request_guard_if.sv
// Request and response valid/ready channels of the AES request guard.
interface aes_request_guard_if;
  import aes_guard_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_plaintext;
  logic [AES_BLOCK_W-1:0] in_key;

  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_ciphertext;
  logic                   out_error;

  modport master (
    output in_valid, in_plaintext, in_key, out_ready,
    input  in_ready, out_valid, out_ciphertext, out_error
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, out_ready,
    output in_ready, out_valid, out_ciphertext, out_error
  );
endinterface

// File: rtl/aes_request_guard_watchdog.sv
// Cycle counter that flags expiry on its TIMEOUT_CYCLES-th enabled cycle.
module aes_watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_timer;

  assign o_expired = i_enable && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_timer <= '0;
    end else if (i_enable && !o_expired) begin
      r_timer <= r_timer + 1'b1;
    end
  end
endmodule

// File: rtl/aes_request_guard.sv
// Transaction controller around the hardened AES-128 top: issue, retry on
// fault/timeout, respond with ciphertext or a zeroized error, lock out on abuse.
module aes_request_guard
  import aes_guard_pkg::*;
#(
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int FAULT_LIMIT    = DEF_FAULT_LIMIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_request_guard_if.slave     bus,
  output logic                   aes_start,
  output logic [AES_BLOCK_W-1:0] aes_plaintext,
  output logic [AES_BLOCK_W-1:0] aes_key,
  input  logic                   aes_valid,
  input  logic                   aes_fault_alert,
  input  logic                   aes_busy,
  input  logic [AES_BLOCK_W-1:0] aes_ciphertext,
  output logic                   locked,
  output logic [CNT_W-1:0]       fault_count
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                 r_state, w_state_nxt;
  logic [AES_BLOCK_W-1:0] r_pt, w_pt_nxt;
  logic [AES_BLOCK_W-1:0] r_key, w_key_nxt;
  logic [AES_BLOCK_W-1:0] r_ct, w_ct_nxt;
  logic                   r_err, w_err_nxt;
  logic [RW-1:0]          r_retry, w_retry_nxt;
  logic [CNT_W-1:0]       r_fault_cnt, w_fault_nxt;
  logic                   r_lock_pend, w_lock_pend_nxt;
  logic [CNT_W-1:0]       w_fault_inc;
  logic                   w_expired;
  logic                   w_fault_evt;

  aes_watchdog_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != WAIT),
    .i_enable  (r_state == WAIT),
    .o_expired (w_expired)
  );

  assign w_fault_inc = sat_inc(r_fault_cnt);
  // A result that lands on the expiry cycle still wins over the timeout.
  assign w_fault_evt = aes_fault_alert || (!aes_valid && w_expired);

  assign bus.in_ready       = (r_state == IDLE) && !rst;
  assign bus.out_valid      = (r_state == RESP);
  assign bus.out_ciphertext = r_ct;
  assign bus.out_error      = r_err;
  assign aes_plaintext      = r_pt;
  assign aes_key            = r_key;
  assign locked             = (r_state == LOCK);
  assign fault_count        = r_fault_cnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_pt_nxt        = r_pt;
    w_key_nxt       = r_key;
    w_ct_nxt        = r_ct;
    w_err_nxt       = r_err;
    w_retry_nxt     = r_retry;
    w_fault_nxt     = r_fault_cnt;
    w_lock_pend_nxt = r_lock_pend;
    aes_start       = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_pt_nxt    = bus.in_plaintext;
          w_key_nxt   = bus.in_key;
          w_retry_nxt = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!aes_busy) begin
          aes_start   = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_fault_evt) begin
          w_fault_nxt = w_fault_inc;
          if (32'(w_fault_inc) >= 32'(FAULT_LIMIT)) begin
            w_lock_pend_nxt = 1'b1;
            w_err_nxt       = 1'b1;
            w_ct_nxt        = '0;
            w_pt_nxt        = '0;
            w_key_nxt       = '0;
            w_state_nxt     = RESP;
          end else if (32'(r_retry) < 32'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_err_nxt   = 1'b1;
            w_ct_nxt    = '0;
            w_pt_nxt    = '0;
            w_key_nxt   = '0;
            w_state_nxt = RESP;
          end
        end else if (aes_valid) begin
          w_ct_nxt    = aes_ciphertext;
          w_err_nxt   = 1'b0;
          w_pt_nxt    = '0;
          w_key_nxt   = '0;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          w_ct_nxt    = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = r_lock_pend ? LOCK : IDLE;
        end
      end
      LOCK: begin
        w_state_nxt = LOCK;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pt        <= '0;
      r_key       <= '0;
      r_ct        <= '0;
      r_err       <= 1'b0;
      r_retry     <= '0;
      r_fault_cnt <= '0;
      r_lock_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pt        <= w_pt_nxt;
      r_key       <= w_key_nxt;
      r_ct        <= w_ct_nxt;
      r_err       <= w_err_nxt;
      r_retry     <= w_retry_nxt;
      r_fault_cnt <= w_fault_nxt;
      r_lock_pend <= w_lock_pend_nxt;
    end
  end
endmodule

// File: tb/tb_aes_request_guard.sv
// Scoreboard bench for aes_request_guard with a scripted AES core stub.
module tb_aes_request_guard;
  import aes_guard_pkg::*;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int K_NONE = 0, K_VALID = 1, K_FAULT = 2, K_BOTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_request_guard_if bus_if();

  logic         aes_start;
  logic [127:0] aes_plaintext, aes_key;
  logic         aes_valid = 1'b0, aes_fault_alert = 1'b0, aes_busy = 1'b0;
  logic [127:0] aes_ciphertext = '0;
  logic         locked;
  logic [7:0]   fault_count;

  aes_request_guard #(
    .MAX_RETRY(2), .FAULT_LIMIT(4), .TIMEOUT_CYCLES(64), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .aes_start(aes_start), .aes_plaintext(aes_plaintext), .aes_key(aes_key),
    .aes_valid(aes_valid), .aes_fault_alert(aes_fault_alert), .aes_busy(aes_busy),
    .aes_ciphertext(aes_ciphertext), .locked(locked), .fault_count(fault_count)
  );

  typedef struct { int kind; int dly; logic [127:0] ct; } plan_t;
  typedef struct { logic [127:0] ct; logic err; } exp_t;
  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0, errors = 0, starts = 0;
  logic [127:0] cur_pt = '0, cur_key = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_plan(input int kind, input int dly, input logic [127:0] ct);
    plan_t p;
    p.kind = kind; p.dly = dly; p.ct = ct;
    plan_q.push_back(p);
  endtask

  task automatic push_exp(input logic [127:0] ct, input logic err);
    exp_t e;
    e.ct = ct; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every response handshake is checked against the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got ct %h err %b required none",
                 bus_if.out_ciphertext, bus_if.out_error);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_ct", bus_if.out_ciphertext, mon_e.ct);
        chki("resp_err", int'(bus_if.out_error), int'(mon_e.err));
      end
    end
  end

  // AES core stub: counts start pulses and answers from the plan queue.
  plan_t stub_p;
  initial begin
    forever begin
      @(negedge clk);
      if (aes_start === 1'b1) begin
        starts++;
        if (plan_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got start required none");
        end else begin
          stub_p = plan_q.pop_front();
          chk("start_pt", aes_plaintext, cur_pt);
          chk("start_key", aes_key, cur_key);
          if (stub_p.kind != K_NONE) begin
            repeat (stub_p.dly) @(posedge clk);
            #1;
            aes_valid       = (stub_p.kind == K_VALID) || (stub_p.kind == K_BOTH);
            aes_fault_alert = (stub_p.kind == K_FAULT) || (stub_p.kind == K_BOTH);
            aes_ciphertext  = stub_p.ct;
            @(posedge clk);
            #1;
            aes_valid       = 1'b0;
            aes_fault_alert = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n;
    n = 0;
    @(posedge clk); #1;
    cur_pt = pt; cur_key = key;
    bus_if.in_valid = 1'b1; bus_if.in_plaintext = pt; bus_if.in_key = key;
    @(negedge clk);
    while (bus_if.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_accept: got in_ready %b required 1", bus_if.in_ready);
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0; bus_if.in_plaintext = '0; bus_if.in_key = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_if.out_valid === 1'b1) && n < budget) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: got %0d responses pending required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chki("in_ready_in_rst", int'(bus_if.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, n;
    bus_if.in_valid = 1'b0; bus_if.in_plaintext = '0; bus_if.in_key = '0;
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chki("in_ready_in_rst", int'(bus_if.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chki("rst_in_ready", int'(bus_if.in_ready), 1);
    chki("rst_out_valid", int'(bus_if.out_valid), 0);
    chki("rst_out_error", int'(bus_if.out_error), 0);
    chk("rst_out_ct", bus_if.out_ciphertext, '0);
    chki("rst_locked", int'(locked), 0);
    chki("rst_fault_count", int'(fault_count), 0);
    chki("rst_aes_start", int'(aes_start), 0);
    chk("rst_aes_pt", aes_plaintext, '0);

    // Clean FIPS-197 request
    s0 = starts;
    push_plan(K_VALID, 11, FIPS_CT);
    push_exp(FIPS_CT, 1'b0);
    send(FIPS_PT, FIPS_KEY);
    wait_done("t1_done", 100);
    chki("t1_starts", starts - s0, 1);
    chki("t1_fault_count", int'(fault_count), 0);
    chk("t1_pt_zeroized", aes_plaintext, '0);
    chk("t1_key_zeroized", aes_key, '0);

    // One fault, then success
    s0 = starts;
    push_plan(K_FAULT, 3, 128'h0);
    push_plan(K_VALID, 5, 128'hdeadbeef_00000000_cafef00d_12345678);
    push_exp(128'hdeadbeef_00000000_cafef00d_12345678, 1'b0);
    send(128'h1111, 128'h2222);
    wait_done("t2_done", 100);
    chki("t2_starts", starts - s0, 2);
    chki("t2_fault_count", int'(fault_count), 1);

    // Retries exhausted
    do_reset();
    s0 = starts;
    repeat (3) push_plan(K_FAULT, 2, 128'h0);
    push_exp(128'h0, 1'b1);
    send(128'h3333, 128'h4444);
    wait_done("t3_done", 150);
    chki("t3_starts", starts - s0, 3);
    chki("t3_fault_count", int'(fault_count), 3);
    chki("t3_in_ready", int'(bus_if.in_ready), 1);
    chki("t3_locked", int'(locked), 0);

    // Fourth cumulative fault locks out
    s0 = starts;
    push_plan(K_FAULT, 2, 128'h0);
    push_exp(128'h0, 1'b1);
    send(128'h5555, 128'h6666);
    wait_done("t4_done", 100);
    chki("t4_starts", starts - s0, 1);
    chki("t4_fault_count", int'(fault_count), 4);
    chki("t4_locked", int'(locked), 1);
    chki("t4_in_ready", int'(bus_if.in_ready), 0);
    s0 = starts;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1; bus_if.in_plaintext = 128'h7777; bus_if.in_key = 128'h8888;
    repeat (100) @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    @(negedge clk);
    chki("t4_lock_starts", starts - s0, 0);
    chki("t4_lock_held", int'(locked), 1);
    chki("t4_lock_out_valid", int'(bus_if.out_valid), 0);
    do_reset();
    chki("t4_rst_in_ready", int'(bus_if.in_ready), 1);
    chki("t4_rst_fault_count", int'(fault_count), 0);
    chki("t4_rst_locked", int'(locked), 0);

    // Timeout with the core held busy for 80 cycles
    s0 = starts;
    push_plan(K_NONE, 0, 128'h0);
    push_plan(K_VALID, 4, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    push_exp(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0);
    send(128'h9999, 128'haaaa);
    n = 0;
    while (aes_start !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chki("t5_first_start", int'(aes_start), 1);
    @(posedge clk); #1 aes_busy = 1'b1;
    repeat (64) @(negedge clk);
    chki("t5_before_timeout", int'(fault_count), 0);
    @(negedge clk);
    chki("t5_at_timeout", int'(fault_count), 1);
    repeat (15) @(negedge clk);
    chki("t5_busy_stall_starts", starts - s0, 1);
    chki("t5_busy_no_start", int'(aes_start), 0);
    @(posedge clk); #1 aes_busy = 1'b0;
    wait_done("t5_done", 100);
    chki("t5_starts", starts - s0, 2);
    chki("t5_fault_count", int'(fault_count), 1);

    // Output backpressure
    bus_if.out_ready = 1'b0;
    push_plan(K_VALID, 2, 128'h55aa55aa_00ff00ff_12121212_abcdabcd);
    push_exp(128'h55aa55aa_00ff00ff_12121212_abcdabcd, 1'b0);
    send(128'hbbbb, 128'hcccc);
    n = 0;
    while (bus_if.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    for (int i = 0; i < 5; i++) begin
      chki("t6_bp_valid", int'(bus_if.out_valid), 1);
      chk("t6_bp_ct", bus_if.out_ciphertext, 128'h55aa55aa_00ff00ff_12121212_abcdabcd);
      chki("t6_bp_err", int'(bus_if.out_error), 0);
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    wait_done("t6_bp_done", 20);

    // Simultaneous valid and fault counts as a fault
    s0 = starts;
    push_plan(K_BOTH, 3, 128'hffff);
    push_plan(K_VALID, 3, 128'h01234567_89abcdef_fedcba98_76543210);
    push_exp(128'h01234567_89abcdef_fedcba98_76543210, 1'b0);
    send(128'hdddd, 128'heeee);
    wait_done("t6_both_done", 100);
    chki("t6_both_starts", starts - s0, 2);
    chki("t6_both_fault_count", int'(fault_count), 2);

    // Reset in the middle of WAIT; the late core result must be ignored
    push_plan(K_VALID, 20, 128'h1234);
    send(128'hf00d, 128'hbeef);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chki("t6_rst_in_ready_low", int'(bus_if.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chki("t6_rst_in_ready", int'(bus_if.in_ready), 1);
    chki("t6_rst_out_valid", int'(bus_if.out_valid), 0);
    chki("t6_rst_out_error", int'(bus_if.out_error), 0);
    chk("t6_rst_out_ct", bus_if.out_ciphertext, '0);
    chki("t6_rst_fault_count", int'(fault_count), 0);
    chki("t6_rst_locked", int'(locked), 0);
    chki("t6_rst_aes_start", int'(aes_start), 0);
    chk("t6_rst_aes_pt", aes_plaintext, '0);
    chk("t6_rst_aes_key", aes_key, '0);
    repeat (30) @(negedge clk);
    chki("t6_late_fault_count", int'(fault_count), 0);
    chki("t6_late_out_valid", int'(bus_if.out_valid), 0);
    chki("t6_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
